// File: rtl/matrix_scale_sequencer_if.sv
// Bundles the decode request, data-memory port and math-unit port of the
// 4x4 matrix scale sequencer. The sequencer side uses the master modport;
// the memory, math unit and decode environment use the slave modport.
interface matrix_scale_sequencer_if #(
    parameter int ADDR_W = 8
) ();
    // decode request and status
    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [7:0]        scalar_in;
    logic              busy;
    logic              done;
    logic              error;

    // data memory port (synchronous RAM, one-cycle read latency)
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [15:0]       mem_rd_data;
    logic              mem_wr_en;
    logic [15:0]       mem_wr_data;

    // math unit port
    logic [255:0]      math_matrix;
    logic [7:0]        math_scalar;
    logic              math_enable;
    logic [255:0]      math_result;
    logic              math_done;

    modport master (
        input  start, src_addr, dst_addr, scalar_in,
        output busy, done, error,
        output mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
        input  mem_rd_data,
        output math_matrix, math_scalar, math_enable,
        input  math_result, math_done
    );

    modport slave (
        output start, src_addr, dst_addr, scalar_in,
        input  busy, done, error,
        input  mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
        output mem_rd_data,
        input  math_matrix, math_scalar, math_enable,
        output math_result, math_done
    );
endinterface

// File: rtl/matrix_scale_sequencer.sv
// Memory-side controller for the 4x4 matrix scaling unit: reads 16 elements,
// packs them onto the 256-bit matrix bus, fires the math unit, waits for it
// (with a timeout) and writes the 16 result elements back to memory.
// Element k lives at base+k and at bus bits [16k+15:16k].
module matrix_scale_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     nreset,
    matrix_scale_sequencer_if.master bus
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                error_q, error_d;
    logic [ADDR_W-1:0]   src_q, dst_q;
    logic [7:0]          scalar_q;
    logic [255:0]        matrix_q;
    logic [255:0]        result_q;

    // control strobes and combinational outputs from the FSM
    logic                latch_en;
    logic                cap_en;
    logic [3:0]          cap_slot;
    logic                res_en;
    logic                busy;
    logic                done;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_rd_en;
    logic                mem_wr_en;
    logic [15:0]         mem_wr_data;
    logic                math_enable;

    // State register and small control counters
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wait_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            error_q <= error_d;
        end
    end

    // Next-state, counter updates and per-state output decode
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wait_d      = wait_q;
        error_d     = error_q;
        latch_en    = 1'b0;
        cap_en      = 1'b0;
        cap_slot    = cnt_q - 4'd1;
        res_en      = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        mem_addr    = '0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        math_enable = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (bus.start) begin
                    latch_en = 1'b1;
                    error_d  = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_READ;
                end
            end
            S_READ: begin
                // data for the address issued last cycle arrives now
                mem_rd_en = 1'b1;
                mem_addr  = src_q + ADDR_W'(cnt_q);
                cap_en    = (cnt_q != 4'd0);
                cnt_d     = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                cap_en   = 1'b1;
                cap_slot = 4'd15;
                state_d  = S_ISSUE;
            end
            S_ISSUE: begin
                // math_done is deliberately not looked at here
                math_enable = 1'b1;
                wait_d      = '0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (bus.math_done) begin
                    res_en  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_WRITE;
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WRITE: begin
                mem_wr_en   = 1'b1;
                mem_addr    = dst_q + ADDR_W'(cnt_q);
                mem_wr_data = result_q[{cnt_q, 4'd0} +: 16];
                cnt_d       = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Operand latches, matrix packing and result capture
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            src_q    <= '0;
            dst_q    <= '0;
            scalar_q <= '0;
            matrix_q <= '0;
            result_q <= '0;
        end else begin
            if (latch_en) begin
                src_q    <= bus.src_addr;
                dst_q    <= bus.dst_addr;
                scalar_q <= bus.scalar_in;
            end
            if (cap_en) begin
                matrix_q[{cap_slot, 4'd0} +: 16] <= bus.mem_rd_data;
            end
            if (res_en) begin
                result_q <= bus.math_result;
            end
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.error       = error_q;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_rd_en   = mem_rd_en;
    assign bus.mem_wr_en   = mem_wr_en;
    assign bus.mem_wr_data = mem_wr_data;
    assign bus.math_matrix = matrix_q;
    assign bus.math_scalar = scalar_q;
    assign bus.math_enable = math_enable;
endmodule

// File: tb/tb_matrix_scale_sequencer.sv
// Randomized self-checking bench for matrix_scale_sequencer. A 256-word
// memory and a behavioural math unit surround the DUT; a reference memory
// image is updated with plain arithmetic per operation and compared after.
module tb_matrix_scale_sequencer;
    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic nreset = 1'b0;

    matrix_scale_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    matrix_scale_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .nreset(nreset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    // memory model and environment state
    logic [15:0] mem     [256];
    logic [15:0] img     [256];
    logic [15:0] ref_mem [256];
    logic        ld_all = 1'b0;
    logic        clr_cnt = 1'b0;
    int          lat_cfg = 0;
    logic        never_cfg = 1'b0;
    int          pend = 0;
    int          rd_cnt, wr_cnt, en_cnt, done_cnt;
    logic [7:0]  rd_log [16];
    logic [7:0]  wr_log [16];
    logic [255:0] res_v;
    logic [31:0]  prod;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // synchronous RAM with a bulk preload port
    always @(posedge clk) begin
        if (ld_all) begin
            for (int i = 0; i < 256; i++) mem[i] <= img[i];
        end else begin
            if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
            if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wr_data;
        end
    end

    // transaction monitor
    always @(posedge clk) begin
        if (clr_cnt) begin
            rd_cnt <= 0; wr_cnt <= 0; en_cnt <= 0; done_cnt <= 0;
        end else begin
            if (bus.mem_rd_en) begin
                if (rd_cnt < 16) rd_log[rd_cnt] <= bus.mem_addr;
                rd_cnt <= rd_cnt + 1;
            end
            if (bus.mem_wr_en) begin
                if (wr_cnt < 16) wr_log[wr_cnt] <= bus.mem_addr;
                wr_cnt <= wr_cnt + 1;
            end
            if (bus.math_enable) en_cnt <= en_cnt + 1;
            if (bus.done) done_cnt <= done_cnt + 1;
        end
    end

    // math unit: done after lat_cfg extra cycles, or never
    always @(posedge clk) begin
        if (!nreset) begin
            bus.math_done <= 1'b0;
            pend <= 0;
        end else if (bus.math_enable && !never_cfg) begin
            if (lat_cfg == 0) bus.math_done <= 1'b1;
            else begin
                pend <= lat_cfg;
                bus.math_done <= 1'b0;
            end
        end else if (pend != 0) begin
            pend <= pend - 1;
            bus.math_done <= (pend == 1);
        end else begin
            bus.math_done <= 1'b0;
        end
    end

    always_comb begin
        res_v = '0;
        prod  = '0;
        for (int k = 0; k < 16; k++) begin
            prod = 32'(bus.math_matrix[16*k +: 16]) * 32'(bus.math_scalar);
            res_v[16*k +: 16] = prod[15:0];
        end
    end
    assign bus.math_result = res_v;

    task automatic load_mem();
        for (int i = 0; i < 256; i++) img[i] = ref_mem[i];
        @(negedge clk); ld_all = 1'b1;
        @(negedge clk); ld_all = 1'b0;
    endtask

    task automatic start_op(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] sc);
        @(negedge clk);
        bus.start = 1'b1; bus.src_addr = src; bus.dst_addr = dst; bus.scalar_in = sc;
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        clr_cnt = 1'b0;
    endtask

    task automatic run_op(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] sc,
                          input int lat, input logic nev, input logic poke);
        logic [15:0]  sv [16];
        logic [255:0] exp_mat;
        int cyc, exp_cyc, mism;
        logic got;
        for (int k = 0; k < 16; k++) begin
            sv[k] = ref_mem[8'(src + 8'(k))];
            exp_mat[16*k +: 16] = sv[k];
        end
        lat_cfg = lat;
        never_cfg = nev;
        start_op(src, dst, sc);
        cyc = 1;
        got = 1'b0;
        while (cyc <= 200 && !got) begin
            @(negedge clk);
            if (cyc == 1) begin
                check_eq("busy_cycle1", 256'(bus.busy), 256'(1));
                check_eq("error_cleared", 256'(bus.error), 256'(0));
            end
            if (bus.done) got = 1'b1;
            else cyc++;
        end
        exp_cyc = nev ? (19 + TIMEOUT) : (36 + lat);
        check_eq("done_cycle", 256'(got ? cyc : 0), 256'(exp_cyc));
        check_eq("error_at_done", 256'(bus.error), 256'(nev));
        if (!nev)
            for (int k = 0; k < 16; k++)
                ref_mem[8'(dst + 8'(k))] = 16'(32'(sv[k]) * 32'(sc));
        check_eq("read_count", 256'(rd_cnt), 256'(16));
        check_eq("write_count", 256'(wr_cnt), 256'(nev ? 0 : 16));
        check_eq("enable_count", 256'(en_cnt), 256'(1));
        check_eq("matrix", bus.math_matrix, exp_mat);
        check_eq("scalar", 256'(bus.math_scalar), 256'(sc));
        mism = 0;
        for (int k = 0; k < 16; k++) if (rd_log[k] !== 8'(src + 8'(k))) mism++;
        check_eq("read_addrs", 256'(mism), 256'(0));
        if (!nev) begin
            mism = 0;
            for (int k = 0; k < 16; k++) if (wr_log[k] !== 8'(dst + 8'(k))) mism++;
            check_eq("write_addrs", 256'(mism), 256'(0));
        end
        mism = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
        check_eq("memory", 256'(mism), 256'(0));
        if (poke) bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        check_eq("idle_after_done", 256'(bus.busy), 256'(0));
        check_eq("error_held", 256'(bus.error), 256'(nev));
        if (poke) check_eq("no_extra_read", 256'(rd_cnt), 256'(16));
        $display("op src=%02h dst=%02h scalar=%02h lat=%0d timeout=%0d done_cycle=%0d",
                 src, dst, sc, lat, nev, cyc);
    endtask

    task automatic reset_mid_write(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] sc);
        logic [15:0] sv [16];
        logic found;
        int mism;
        for (int k = 0; k < 16; k++) sv[k] = ref_mem[8'(src + 8'(k))];
        lat_cfg = 0;
        never_cfg = 1'b0;
        start_op(src, dst, sc);
        found = 1'b0;
        for (int t = 0; t < 100 && !found; t++) begin
            @(negedge clk);
            if (bus.mem_wr_en && bus.mem_addr == 8'(dst + 8'd5)) found = 1'b1;
        end
        check_eq("reach_write5", 256'(found), 256'(1));
        nreset = 1'b0;
        #1;
        check_eq("rst_ctl", 256'({bus.busy, bus.done, bus.error, bus.mem_rd_en,
                                  bus.mem_wr_en, bus.math_enable}), 256'(0));
        check_eq("rst_addr", 256'({bus.mem_addr, bus.mem_wr_data}), 256'(0));
        check_eq("rst_matrix", bus.math_matrix, 256'(0));
        check_eq("rst_scalar", 256'(bus.math_scalar), 256'(0));
        for (int k = 0; k < 5; k++) ref_mem[8'(dst + 8'(k))] = 16'(32'(sv[k]) * 32'(sc));
        @(negedge clk);
        nreset = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_writes", 256'(wr_cnt), 256'(5));
        check_eq("rst_no_done", 256'(done_cnt), 256'(0));
        check_eq("rst_busy", 256'(bus.busy), 256'(0));
        mism = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
        check_eq("rst_memory", 256'(mism), 256'(0));
        $display("reset mid-write src=%02h dst=%02h writes=%0d", src, dst, wr_cnt);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.src_addr = '0;
        bus.dst_addr = '0;
        bus.scalar_in = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'($urandom);
        repeat (3) @(negedge clk);
        check_eq("reset_ctl", 256'({bus.busy, bus.done, bus.error, bus.mem_rd_en,
                                    bus.mem_wr_en, bus.math_enable}), 256'(0));
        check_eq("reset_data", 256'({bus.mem_addr, bus.mem_wr_data, bus.math_scalar}), 256'(0));
        check_eq("reset_matrix", bus.math_matrix, 256'(0));
        for (int k = 0; k < 16; k++) ref_mem[k] = 16'(k + 1);
        for (int k = 0; k < 16; k++) ref_mem[8'h40 + k] = 16'hA000 + 16'(k);
        ref_mem[8'h10] = 16'h4000;
        ref_mem[8'h11] = 16'h0FFF;
        load_mem();
        @(negedge clk);
        nreset = 1'b1;

        // basic scale: 1..16 x 3
        run_op(8'h00, 8'h20, 8'd3, 0, 1'b0, 1'b0);
        check_eq("basic_first", 256'(mem[8'h20]), 256'(3));
        check_eq("basic_last", 256'(mem[8'h2F]), 256'(48));

        // packing order
        run_op(8'h40, 8'h80, 8'd1, 1, 1'b0, 1'b0);
        check_eq("pack_e0", 256'(bus.math_matrix[15:0]), 256'(16'hA000));
        check_eq("pack_e4", 256'(bus.math_matrix[79:64]), 256'(16'hA004));
        check_eq("pack_e15", 256'(bus.math_matrix[255:240]), 256'(16'hA00F));

        // truncation
        run_op(8'h10, 8'h60, 8'h08, 0, 1'b0, 1'b0);
        check_eq("trunc_4000x8", 256'(mem[8'h60]), 256'(16'h0000));
        run_op(8'h10, 8'h70, 8'h02, 2, 1'b0, 1'b0);
        check_eq("trunc_0FFFx2", 256'(mem[8'h71]), 256'(16'h1FFE));

        // wrap and in-place overlap
        run_op(8'hF8, 8'hF8, 8'd1, 0, 1'b0, 1'b0);

        // timeout, then the next start clears error
        run_op(8'h30, 8'h90, 8'd5, 0, 1'b1, 1'b0);
        run_op(8'h30, 8'h90, 8'd5, 0, 1'b0, 1'b0);

        // randomized operations, last one with a start poked during DONE
        for (int n = 0; n < 6; n++) begin
            run_op(8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 4)),
                   1'b0, (n == 5) ? 1'b1 : 1'b0);
        end

        // reset during write element 5
        reset_mid_write(8'h05, 8'hC0, 8'd7);

        // sequencer still works after the abort
        run_op(8'($urandom), 8'hD0, 8'($urandom), 0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/matrix_scale_sequencer.md
# matrix_scale_sequencer

Memory-side controller for the 4x4 matrix scaling unit. It fetches sixteen 16-bit elements from data memory, packs them into the 256-bit flattened matrix bus, pulses the math unit's enable, captures the 256-bit result when the unit reports done, and unpacks it back to memory one element per cycle. It sits between instruction decode and the math module: it is the writer of `matrix`/`scalar`/`enable` and the reader of `m_out`/`done`.

## Interface
- ADDR_W, 8, width of the memory address bus; all address arithmetic wraps modulo 2^ADDR_W
- TIMEOUT, 16, maximum cycles spent in WAIT before the operation is aborted
- clk  input  1  system clock; all state updates on the rising edge
- nreset  input  1  asynchronous active-low reset
- start  input  1  one-cycle request from decode; sampled only in IDLE
- src_addr  input  ADDR_W  base address of the source matrix; latched on an accepted start
- dst_addr  input  ADDR_W  base address of the destination matrix; latched on an accepted start
- scalar_in  input  8  scale factor; latched on an accepted start
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when the operation finishes
- error  output  1  sticky flag, set on WAIT timeout; cleared by the next accepted start
- mem_addr  output  ADDR_W  memory address for both reads and writes
- mem_rd_en  output  1  read strobe; the synchronous RAM returns data on the next cycle
- mem_rd_data  input  16  read data, valid the cycle after mem_rd_en
- mem_wr_en  output  1  write strobe
- mem_wr_data  output  16  write data
- math_matrix  output  256  packed matrix to the math unit
- math_scalar  output  8  latched scalar to the math unit
- math_enable  output  1  one-cycle operation request to the math unit
- math_result  input  256  packed result from the math unit
- math_done  input  1  completion flag from the math unit

## Operation
- Element k (0..15) is at row r = k/4 and col c = k%4. It is stored at address base+k and occupies bus bits [16k+15 : 16k], which is row*64 + col*16.
- State machine: IDLE -> READ -> DRAIN -> ISSUE -> WAIT -> WRITE -> DONE -> IDLE.
- IDLE: if start=1, latch src_addr, dst_addr and scalar_in, clear error, clear the element counter, and go to READ. Otherwise stay in IDLE.
- READ: 16 cycles. Drive mem_rd_en=1 and mem_addr=src+k. From the second READ cycle onward, capture mem_rd_data into slot k-1.
- DRAIN: 1 cycle. Capture mem_rd_data into slot 15. mem_rd_en=0.
- ISSUE: 1 cycle. math_matrix is already stable. Drive math_enable=1.
- WAIT: sample math_done each cycle, starting the cycle after ISSUE. On 1, capture math_result into the result register and go to WRITE. After TIMEOUT cycles without math_done, set error=1 and go to DONE with no writes.
- WRITE: 16 cycles. Drive mem_wr_en=1, mem_addr=dst+k, and mem_wr_data = result bits [16k+15:16k].
- DONE: 1 cycle with done=1, then return to IDLE.
- Result elements are the math unit's low 16 bits, written unmodified. No saturation is applied.
- start is ignored whenever busy=1, including during the DONE cycle.
- src and dst ranges may overlap. All reads complete before the first write, so the results are well defined.
- Address wrap: src=8'hF8 reads 8'hF8..8'hFF and then 8'h00..8'h07.

## Timing
- Reset (nreset=0, effective immediately):
  - State returns to IDLE.
  - busy, done, error, mem_rd_en, mem_wr_en and math_enable are 0.
  - mem_addr, mem_wr_data, math_matrix and math_scalar are 0.
  - The result register is cleared.
- Reset mid-operation aborts immediately. No further memory writes occur, and no done pulse is produced.
- Nominal latency: start sampled at edge E0. busy rises after E0. READ occupies cycles 1-16, DRAIN 17, ISSUE 18, WAIT 19 (math_done already 1), WRITE 20-35, DONE 36.
- Total is 36 cycles from start to the done pulse, plus 1 for each extra WAIT cycle.
- math_enable is high for exactly one cycle per operation. math_matrix and math_scalar are held constant from DRAIN exit until the next accepted start.
- A stale math_done=1 during ISSUE is ignored. Only WAIT samples it.
- On timeout, done pulses 1 cycle after the last WAIT cycle with error=1. mem_wr_en never asserts.

## Test plan
- Basic scale: memory[0..15]=1..16, src=0, dst=32, scalar=3, behavioral scaler model -> memory[32..47]=3,6,...,48; done pulses at cycle 36; exactly 16 reads and 16 writes.
- Truncation: element 16'h4000, scalar=8'h08 -> written value 16'h0000; element 16'h0FFF, scalar=2 -> 16'h1FFE.
- Packing order: memory[k]=16'hA000+k -> math_matrix[15:0]=A000, [79:64]=A004 (row1,col0), [255:240]=A00F.
- Wrap and overlap: src=dst=8'hF8, scalar=1 -> reads F8..07, same values written back in place; no out-of-range address observed.
- Timeout: math_done held 0 -> error=1 and done pulse 17 cycles after ISSUE; no mem_wr_en; next start clears error.
- Reset mid-write plus start while busy: assert nreset=0 at WRITE element 5 -> outputs 0 at once, only elements 0-4 written; a start pulsed during DONE is not accepted (busy stays 0 afterward).
